// File: rtl/seq_divmod.sv
// seq_divmod: multi-cycle restoring divider producing quotient and remainder.
// One quotient bit per clock, start/done handshake, divide-by-zero flag and
// optional two's-complement (truncating) mode.
module seq_divmod #(
    parameter int DATAWIDTH = 64,
    parameter bit SIGNED    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] q,
    output logic [DATAWIDTH-1:0] r,
    output logic                 div_zero
);

    localparam int W  = DATAWIDTH;
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W:0]      rem_q, rem_d;     // partial remainder, one extra bit for the borrow
    logic [W-1:0]    dvd_q, dvd_d;     // dividend shifts out the top, quotient bits shift in
    logic [W-1:0]    dvs_q, dvs_d;     // divisor magnitude
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic [W-1:0]    q_q, q_d;
    logic [W-1:0]    r_q, r_d;
    logic            dz_q, dz_d;

    logic            a_neg, b_neg;
    logic [W-1:0]    a_mag, b_mag;
    logic [W+1:0]    rem_sh;
    logic [W+1:0]    trial;
    logic            borrow;
    logic [W:0]      rem_nx;
    logic [W-1:0]    quo_nx;
    logic [W-1:0]    q_fix, r_fix;
    logic            accept;

    // Operand magnitudes and one restoring-division step.
    always_comb begin
        a_neg  = SIGNED && a[W-1];
        b_neg  = SIGNED && b[W-1];
        a_mag  = a_neg ? ('0 - a) : a;
        b_mag  = b_neg ? ('0 - b) : b;
        rem_sh = {rem_q, dvd_q[W-1]};
        trial  = rem_sh - {2'b00, dvs_q};
        borrow = trial[W+1];
        rem_nx = borrow ? rem_sh[W:0] : trial[W:0];
        quo_nx = {dvd_q[W-2:0], ~borrow};
        q_fix  = negq_q ? ('0 - quo_nx) : quo_nx;
        r_fix  = negr_q ? ('0 - rem_nx[W-1:0]) : rem_nx[W-1:0];
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        accept  = 1'b0;

        unique case (state_q)
            IDLE: accept = start;
            CALC: begin
                rem_d = rem_nx;
                dvd_d = quo_nx;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    q_d     = q_fix;
                    r_d     = r_fix;
                    dz_d    = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                // The edge leaving DONE can already accept the next request,
                // so back-to-back operations lose no cycle.
                accept  = start;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            if (b == '0) begin
                state_d = DONE;
                q_d     = '1;
                r_d     = a;
                dz_d    = 1'b1;
            end else begin
                state_d = CALC;
                cnt_d   = CW'(W - 1);
                rem_d   = '0;
                dvd_d   = a_mag;
                dvs_d   = b_mag;
                negq_d  = a_neg ^ b_neg;
                negr_d  = a_neg;
            end
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        q        = q_q;
        r        = r_q;
        div_zero = dz_q;
    end

endmodule

// File: tb/tb_seq_divmod.sv
// tb_seq_divmod: directed scoreboard bench for seq_divmod (64-bit unsigned
// and 8-bit signed instances).
module tb_seq_divmod;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        dz;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start64 = 1'b0;
    logic [63:0] a64 = '0, b64 = '0;
    logic        busy64, done64, dz64;
    logic [63:0] q64o, r64o;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, dz8;
    logic [7:0]  q8o, r8o;

    int          tests = 0;
    int          fails = 0;

    exp_t        exp64[$];
    exp_t        exp8[$];
    exp_t        e64m, e8m;

    always #5 clk = ~clk;

    seq_divmod #(.DATAWIDTH(64), .SIGNED(1'b0)) dut64 (
        .clk(clk), .rst(rst), .start(start64), .a(a64), .b(b64),
        .busy(busy64), .done(done64), .q(q64o), .r(r64o), .div_zero(dz64)
    );

    seq_divmod #(.DATAWIDTH(8), .SIGNED(1'b1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .q(q8o), .r(r8o), .div_zero(dz8)
    );

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Monitor for the 64-bit instance: compare each completion to the queue head.
    always @(negedge clk) begin
        if (done64 === 1'b1) begin
            if (exp64.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dut64_unexpected_done: got done=1 expected no completion");
            end else begin
                e64m = exp64.pop_front();
                chk({e64m.nm, "_q"}, q64o, e64m.q);
                chk({e64m.nm, "_r"}, r64o, e64m.r);
                chk({e64m.nm, "_dz"}, {63'b0, dz64}, {63'b0, e64m.dz});
            end
        end
    end

    // Monitor for the 8-bit signed instance.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (exp8.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dut8_unexpected_done: got done=1 expected no completion");
            end else begin
                e8m = exp8.pop_front();
                chk({e8m.nm, "_q"}, {56'b0, q8o}, {56'b0, e8m.q[7:0]});
                chk({e8m.nm, "_r"}, {56'b0, r8o}, {56'b0, e8m.r[7:0]});
                chk({e8m.nm, "_dz"}, {63'b0, dz8}, {63'b0, e8m.dz});
            end
        end
    end

    task automatic push(input bit s8, input logic [63:0] eq, input logic [63:0] er,
                        input logic edz, input string nm);
        exp_t e;
        e.q  = eq;
        e.r  = er;
        e.dz = edz;
        e.nm = nm;
        if (s8) exp8.push_back(e);
        else    exp64.push_back(e);
    endtask

    // Drive a request and pass the accepting edge; returns 1 time unit after it.
    task automatic launch(input bit s8, input logic [63:0] av, input logic [63:0] bv);
        if (s8) begin
            a8 = av[7:0]; b8 = bv[7:0]; start8 = 1'b1;
        end else begin
            a64 = av; b64 = bv; start64 = 1'b1;
        end
        @(posedge clk);
        #1;
        start8  = 1'b0;
        start64 = 1'b0;
    endtask

    // Count edges until done is seen; lat is the expected edge count.
    task automatic wait_done(input bit s8, input int lat, input string nm);
        int n = 0;
        while (!(s8 ? done8 : done64) && n < lat + 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!(s8 ? done8 : done64)) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done after %0d edges expected done after %0d", nm, n, lat);
        end else begin
            chk({nm, "_latency"}, 64'(n), 64'(lat));
        end
    endtask

    task automatic issue(input bit s8, input logic [63:0] av, input logic [63:0] bv,
                         input logic [63:0] eq, input logic [63:0] er, input logic edz,
                         input int lat, input string nm);
        push(s8, eq, er, edz, nm);
        launch(s8, av, bv);
        wait_done(s8, lat, nm);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_busy", {63'b0, busy64}, 64'd0);
        chk("rst_done", {63'b0, done64}, 64'd0);
        chk("rst_q", q64o, 64'd0);
        chk("rst_r", r64o, 64'd0);
        chk("rst_dz", {63'b0, dz64}, 64'd0);
        chk("rst8_busy", {63'b0, busy8}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        idle();

        // 1: basic 100/10
        push(1'b0, 64'd10, 64'd0, 1'b0, "t1");
        launch(1'b0, 64'd100, 64'd10);
        chk("t1_busy_after_E0", {63'b0, busy64}, 64'd1);
        wait_done(1'b0, 64, "t1");
        idle();
        chk("t1_busy_after_E65", {63'b0, busy64}, 64'd0);
        chk("t1_done_after_E65", {63'b0, done64}, 64'd0);

        // 2: back-to-back, second start raised while done is high
        issue(1'b0, 64'd100, 64'd8, 64'd12, 64'd4, 1'b0, 64, "t2a");
        push(1'b0, 64'd1, 64'd0, 1'b0, "t2b");
        launch(1'b0, 64'd1, 64'd1);
        chk("t2_busy_after_E65", {63'b0, busy64}, 64'd1);
        chk("t2_done_after_E65", {63'b0, done64}, 64'd0);
        wait_done(1'b0, 64, "t2b");
        idle();

        // 3: divide by zero, then a normal op clears the flag
        issue(1'b0, 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 0, "t3z");
        idle();
        issue(1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 1'b0, 64, "t3n");
        idle();

        // 4: start pulsed during CALC is ignored
        push(1'b0, 64'd3, 64'd1, 1'b0, "t4");
        launch(1'b0, 64'd7, 64'd2);
        repeat (10) @(posedge clk);
        #1;
        launch(1'b0, 64'd9, 64'd3);
        wait_done(1'b0, 53, "t4");
        idle();
        chk("t4_single_done", {63'b0, done64}, 64'd0);
        chk("t4_idle_busy", {63'b0, busy64}, 64'd0);
        repeat (5) idle();

        // 5: asynchronous abort mid-operation
        launch(1'b0, 64'd100, 64'd10);
        repeat (19) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("t5_abort_busy", {63'b0, busy64}, 64'd0);
        chk("t5_abort_done", {63'b0, done64}, 64'd0);
        chk("t5_abort_q", q64o, 64'd0);
        chk("t5_abort_r", r64o, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle();
        issue(1'b0, 64'd100, 64'd4, 64'd25, 64'd0, 1'b0, 64, "t5");
        idle();

        // 6: 8-bit signed
        issue(1'b1, 64'hF9, 64'h02, 64'hFD, 64'hFF, 1'b0, 8, "t6_m7_2");
        idle();
        issue(1'b1, 64'h07, 64'hFE, 64'hFD, 64'h01, 1'b0, 8, "t6_7_m2");
        idle();
        issue(1'b1, 64'h80, 64'hFF, 64'h80, 64'h00, 1'b0, 8, "t6_min_m1");
        idle();
        issue(1'b1, 64'h85, 64'h00, 64'hFF, 64'h85, 1'b1, 0, "t6_zero");
        idle();
        repeat (3) idle();

        chk("pending64", 64'(exp64.size()), 64'd0);
        chk("pending8", 64'(exp8.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
